// File: rtl/spi_slave_fl.sv
// SPI mode-3 flash-style target: decodes command/address and streams 32-bit
// words between the SPI pins and a simple single-cycle-latency memory backend.
module spi_slave_fl #(
  parameter int          ADDR_W       = 24,
  parameter int          DUMMY_CYCLES = 8,
  parameter logic [31:0] ID_VALUE     = 32'h00EF4018
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              cmd_valid,
  output logic [7:0]        cmd,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic [7:0]        status_in,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;
  typedef enum logic [2:0] {OP_READ, OP_FAST, OP_PROG, OP_ID, OP_STAT} op_t;

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  state_t            state_q, state_d;
  op_t               op_q;
  logic [2:0]        sclk_sync, ss_sync;
  logic [1:0]        mosi_sync;
  logic [2:0]        ss_vld;
  logic [7:0]        cnt;
  logic [31:0]       shreg;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_pending;

  logic              edge_en, rise, fall, ss_fall, ss_rise, mosi_s;
  logic [7:0]        cmd_byte;
  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       wr_word;

  // ss_vld keeps the reset value of the ss_n synchroniser from looking like a
  // select edge, so a frame only starts on a genuine ss_n fall after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 3'b111;
      ss_sync   <= 3'b111;
      mosi_sync <= 2'b00;
      ss_vld    <= 3'b000;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      ss_sync   <= {ss_sync[1:0], ss_n};
      mosi_sync <= {mosi_sync[0], mosi};
      ss_vld    <= {ss_vld[1:0], 1'b1};
    end
  end

  assign mosi_s    = mosi_sync[1];
  assign edge_en   = ~ss_sync[1] & ~ss_sync[2];
  assign rise      = edge_en & sclk_sync[1] & ~sclk_sync[2];
  assign fall      = edge_en & ~sclk_sync[1] & sclk_sync[2];
  assign ss_fall   = ss_vld[2] & ~ss_sync[1] & ss_sync[2];
  assign ss_rise   = ss_sync[1] & ~ss_sync[2];
  assign busy      = ~ss_sync[1];
  assign miso_oe   = (state_q == RDATA);
  assign cmd_byte  = {shreg[6:0], mosi_s};
  assign addr_next = {addr_q[ADDR_W-2:0], mosi_s};
  assign wr_word   = {shreg[30:0], mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (ss_fall) state_d = CMD;
        CMD:   if (rise && cnt == 8'd7) begin
                 case (cmd_byte)
                   8'h03, 8'h0B, 8'h02: state_d = ADDR;
                   8'h9F, 8'h05:        state_d = RDATA;
                   default:             state_d = IGNORE;
                 endcase
               end
        ADDR:  if (rise && cnt == ADDR_LAST) begin
                 if (op_q == OP_PROG)                           state_d = WDATA;
                 else if (op_q == OP_FAST && DUMMY_CYCLES != 0) state_d = DUMMY;
                 else                                           state_d = RDATA;
               end
        DUMMY: if (rise && cnt == DUMMY_LAST) state_d = RDATA;
        default: ;
      endcase
    end
  end

  // Datapath: rd_req is issued on the edge that finishes addr/dummy (or after
  // bit 0 of a word), and the response is loaded one clk after rd_req drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_READ;
      cnt        <= 8'd0;
      shreg      <= 32'd0;
      addr_q     <= '0;
      rd_pending <= 1'b0;
      miso       <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd        <= 8'd0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 32'd0;
    end else begin
      cmd_valid  <= 1'b0;
      rd_req     <= 1'b0;
      wr_valid   <= 1'b0;
      rd_pending <= rd_req;
      if (ss_rise) begin
        miso       <= 1'b0;
        cnt        <= 8'd0;
        rd_pending <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            miso <= 1'b0;
            cnt  <= 8'd0;
          end
          CMD: if (rise) begin
            shreg <= wr_word;
            cnt   <= cnt + 8'd1;
            if (cnt == 8'd7) begin
              cnt       <= 8'd0;
              cmd_valid <= 1'b1;
              cmd       <= cmd_byte;
              case (cmd_byte)
                8'h03: op_q <= OP_READ;
                8'h0B: op_q <= OP_FAST;
                8'h02: op_q <= OP_PROG;
                8'h9F: begin op_q <= OP_ID;   shreg <= ID_VALUE;        end
                8'h05: begin op_q <= OP_STAT; shreg <= {4{status_in}}; end
                default: ;
              endcase
            end
          end
          ADDR: if (rise) begin
            addr_q <= addr_next;
            cnt    <= cnt + 8'd1;
            if (cnt == ADDR_LAST) begin
              cnt <= 8'd0;
              if (op_q == OP_READ || (op_q == OP_FAST && DUMMY_CYCLES == 0)) begin
                rd_req  <= 1'b1;
                rd_addr <= addr_next;
              end
            end
          end
          DUMMY: if (rise) begin
            cnt <= cnt + 8'd1;
            if (cnt == DUMMY_LAST) begin
              cnt     <= 8'd0;
              rd_req  <= 1'b1;
              rd_addr <= addr_q;
            end
          end
          RDATA: begin
            if (fall) begin
              miso  <= shreg[31];
              shreg <= {shreg[30:0], 1'b0};
              cnt   <= cnt + 8'd1;
              if (cnt == 8'd31) begin
                cnt <= 8'd0;
                case (op_q)
                  OP_ID:   shreg <= ID_VALUE;
                  OP_STAT: shreg <= {4{status_in}};
                  default: begin
                    rd_req  <= 1'b1;
                    rd_addr <= rd_addr + ADDR_W'(4);
                  end
                endcase
              end
            end else if (rd_pending) begin
              shreg <= rd_data;
            end
          end
          WDATA: if (rise) begin
            shreg <= wr_word;
            cnt   <= cnt + 8'd1;
            if (cnt == 8'd31) begin
              cnt      <= 8'd0;
              wr_valid <= 1'b1;
              wr_data  <= wr_word;
              wr_addr  <= addr_q;
              addr_q   <= addr_q + ADDR_W'(4);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
